// File: rtl/sync_3bit_up_counter.sv
// Synchronous modulo-MODULUS up counter with parallel load, clear, cascade carry and wrap status.
// Latency: q, wrap, wrapped and load_err update one clock after the controls are sampled; qbar and tc are combinational.
// Backpressure: none; every control input is accepted on every rising edge.
module sync_3bit_up_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap,
    output logic             wrapped,
    output logic             load_err
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("sync_3bit_up_counter: MODULUS must lie in 2 .. 2**WIDTH");
        end
    endgenerate

    // Comparisons are done one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_wrapped;
    logic             r_load_err;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_wrapped_nxt;
    logic             w_load_err_nxt;
    logic             w_at_term;
    logic             w_over_range;
    logic             w_load_ok;

    assign w_at_term    = (r_q == TERM);
    assign w_over_range = ({1'b0, r_q} >= MOD_EXT);
    assign w_load_ok    = ({1'b0, load_val} < MOD_EXT);

    always_comb begin
        w_q_nxt        = r_q;
        w_wrap_nxt     = 1'b0;
        w_wrapped_nxt  = r_wrapped;
        w_load_err_nxt = 1'b0;
        if (clr) begin
            w_q_nxt       = '0;
            w_wrapped_nxt = 1'b0;
        end else if (load) begin
            w_q_nxt        = w_load_ok ? load_val : TERM;
            w_load_err_nxt = ~w_load_ok;
        end else if (en) begin
            // An illegal code recovers to zero as if it had been the terminal count.
            if (w_at_term || w_over_range) begin
                w_q_nxt       = '0;
                w_wrap_nxt    = 1'b1;
                w_wrapped_nxt = 1'b1;
            end else begin
                w_q_nxt = r_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_wrapped  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_wrap     <= w_wrap_nxt;
            r_wrapped  <= w_wrapped_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign q        = r_q;
    assign qbar     = ~r_q;
    assign tc       = en & w_at_term & ~clr & ~load;
    assign wrap     = r_wrap;
    assign wrapped  = r_wrapped;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_sync_3bit_up_counter.sv
// Scoreboard bench: directed vectors carry the outputs expected in the cycle they are applied.
module tb_sync_3bit_up_counter;

    typedef struct {
        int         id;
        logic       en, clr, load;
        logic [2:0] lv;
        logic [2:0] q;
        logic       tc, wrap, wrapped, lerr;
        logic [2:0] q2;
        logic       wrap2, wrapped2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] en_v = '0, clr_v = '0, load_v = '0;
    logic [2:0] lv_v [3];

    logic [2:0] q8, qb8, q5, qb5, qa, qba, qb, qbb;
    logic       tc8, wr8, wd8, le8, tc5, wr5, wd5, le5;
    logic       tca, wra, wda, lea, tcb, wrb, wdb, leb;

    int   tests = 0;
    int   fails = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    sync_3bit_up_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .clr(clr_v[0]), .load(load_v[0]), .load_val(lv_v[0]),
        .q(q8), .qbar(qb8), .tc(tc8), .wrap(wr8), .wrapped(wd8), .load_err(le8));

    sync_3bit_up_counter #(.WIDTH(3), .MODULUS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .clr(clr_v[1]), .load(load_v[1]), .load_val(lv_v[1]),
        .q(q5), .qbar(qb5), .tc(tc5), .wrap(wr5), .wrapped(wd5), .load_err(le5));

    sync_3bit_up_counter #(.WIDTH(3), .MODULUS(8)) stage_a (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .clr(clr_v[2]), .load(load_v[2]), .load_val(lv_v[2]),
        .q(qa), .qbar(qba), .tc(tca), .wrap(wra), .wrapped(wda), .load_err(lea));

    sync_3bit_up_counter #(.WIDTH(3), .MODULUS(8)) stage_b (
        .clk(clk), .rst_n(rst_n), .en(tca), .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .q(qb), .qbar(qbb), .tc(tcb), .wrap(wrb), .wrapped(wdb), .load_err(leb));

    function automatic vec_t mk(int id, bit en, bit clr, bit load, logic [2:0] lv,
                                logic [2:0] q, bit tc, bit wrap, bit wrapped, bit lerr,
                                logic [2:0] q2 = 3'd0, bit wrap2 = 1'b0, bit wrapped2 = 1'b0);
        vec_t v;
        v.id = id; v.en = en; v.clr = clr; v.load = load; v.lv = lv;
        v.q = q; v.tc = tc; v.wrap = wrap; v.wrapped = wrapped; v.lerr = lerr;
        v.q2 = q2; v.wrap2 = wrap2; v.wrapped2 = wrapped2;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #2;
        en_v = '0; clr_v = '0; load_v = '0;
        en_v[v.id]   = v.en;
        clr_v[v.id]  = v.clr;
        load_v[v.id] = v.load;
        lv_v[v.id]   = v.lv;
        sb.push_back(v);
    endtask

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: outputs are stable at the falling edge, between stimulus and the next active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            vec_t        v;
            logic [14:0] act, exp;
            v = sb.pop_front();
            exp = {v.q2, v.wrap2, v.wrapped2, v.q, ~v.q, v.tc, v.wrap, v.wrapped, v.lerr};
            case (v.id)
                0:       act = {5'b0, q8, qb8, tc8, wr8, wd8, le8};
                1:       act = {5'b0, q5, qb5, tc5, wr5, wd5, le5};
                default: act = {qb, wrb, wdb, qa, qba, tca, wra, wda, lea};
            endcase
            chk($sformatf("dut%0d q=%0d", v.id, v.q), act, exp);
        end
    end

    initial begin
        lv_v[0] = '0; lv_v[1] = '0; lv_v[2] = '0;

        // Reset held: tc must stay low even with en asserted.
        en_v[0] = 1'b1;
        #3;
        chk("reset_state", {5'b0, q8, qb8, tc8, wr8, wd8, le8}, {5'b0, 3'd0, 3'd7, 4'b0000});
        en_v[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Free count, MODULUS 8.
        for (int i = 0; i < 8; i++) apply(mk(0, 1, 0, 0, 0, 3'(i), i == 7, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd0, 0, 1, 1, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 1, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd2, 0, 0, 1, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd3, 0, 0, 1, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd4, 0, 0, 1, 0));
        apply(mk(0, 0, 0, 0, 0, 3'd5, 0, 0, 1, 0));

        // Async reset between edges at q=5 with wrapped set.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {5'b0, q8, qb8, tc8, wr8, wd8, le8}, {5'b0, 3'd0, 3'd7, 4'b0000});
        @(posedge clk);
        #1 rst_n = 1'b1;

        apply(mk(0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 1, 7, 3'd2, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 3'd7, 1, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 0));
        apply(mk(0, 0, 0, 1, 7, 3'd0, 0, 0, 1, 0));
        apply(mk(0, 1, 1, 1, 3, 3'd7, 0, 0, 1, 0));   // clr beats load and en
        apply(mk(0, 0, 0, 1, 7, 3'd0, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 1, 2, 3'd7, 0, 0, 0, 0));   // load beats en at terminal count
        apply(mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0));

        // MODULUS 5: sequence, loads in and out of range.
        for (int i = 0; i < 5; i++) apply(mk(1, 1, 0, 0, 0, 3'(i), i == 4, 0, 0, 0));
        apply(mk(1, 1, 0, 0, 0, 3'd0, 0, 1, 1, 0));
        apply(mk(1, 0, 0, 1, 3, 3'd1, 0, 0, 1, 0));
        apply(mk(1, 0, 0, 1, 6, 3'd3, 0, 0, 1, 0));
        apply(mk(1, 0, 0, 0, 0, 3'd4, 0, 0, 1, 1));
        apply(mk(1, 1, 0, 0, 0, 3'd4, 1, 0, 1, 0));
        apply(mk(1, 1, 0, 1, 7, 3'd0, 0, 1, 1, 0));
        apply(mk(1, 0, 1, 0, 0, 3'd4, 0, 0, 1, 1));
        apply(mk(1, 1, 1, 1, 7, 3'd0, 0, 0, 0, 0));   // clr suppresses load_err
        apply(mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));

        // Cascade: stage_b counts once per stage_a wrap.
        for (int i = 0; i <= 64; i++)
            apply(mk(2, i < 64, 0, 0, 0, 3'(i % 8), (i < 64) && (i % 8 == 7),
                     (i > 0) && (i % 8 == 0), i >= 8, 0,
                     3'((i / 8) % 8), i == 64, i == 64));

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
